// File: rtl/fmap_feeder_pkg.sv
// fmap_feeder_pkg: shared CNN feeder state encoding and FIFO sizing helpers
package fmap_feeder_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, STREAM, DONE} state_t;
  localparam int FIFO_DEPTH = 32;
  function automatic int cnt_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fmap_feeder_if.sv
// fmap_feeder_if: loader/conv2D-side bundle of the feature-map feeder
interface fmap_feeder_if import fmap_feeder_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = FIFO_DEPTH
);
  logic wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic start;
  logic rd_en;
  logic valid_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic full;
  logic empty;
  logic [cnt_bits(DEPTH)-1:0] count;
  logic frame_done;
  logic overflow;
  logic underflow;
  modport master (
    output wr_en, wr_data, start, rd_en,
    input valid_out, data_out, full, empty, count, frame_done, overflow, underflow
  );
  modport slave (
    input wr_en, wr_data, start, rd_en,
    output valid_out, data_out, full, empty, count, frame_done, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through storage with wrapping pointers
module sync_fifo_fwft import fmap_feeder_pkg::*; #(
  parameter int DW = 32,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic i_wr_en,
  input  logic [DW-1:0] i_wr_data,
  input  logic i_rd_en,
  output logic [DW-1:0] o_data,
  output logic o_full,
  output logic o_empty,
  output logic [cnt_bits(DEPTH)-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_bits(DEPTH);
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic w_push, w_pop;
  assign o_full = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];
  // a pop frees a slot in the same edge, so a full FIFO still accepts a paired write
  assign w_pop = i_rd_en && !o_empty;
  assign w_push = i_wr_en && (!o_full || i_rd_en);
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/fmap_feeder.sv
// fmap_feeder: buffers loader pixels and streams one padded frame per start to conv2D
module fmap_feeder import fmap_feeder_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int FRAME_PIX = 9,
  parameter int FRAME_CYC = 30
) (
  input logic clk,
  input logic rst,
  fmap_feeder_if.slave f
);
  localparam int CW = cnt_bits(DEPTH);
  localparam int TW = $clog2(FRAME_CYC + 1);
  state_t r_state;
  logic [TW-1:0] r_cyc;
  logic r_valid, r_done, r_ovf, r_udf;
  logic w_full, w_empty;
  logic [CW-1:0] w_count;
  logic [DATA_WIDTH-1:0] w_data;
  sync_fifo_fwft #(.DW(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_wr_en(f.wr_en),
    .i_wr_data(f.wr_data),
    .i_rd_en(f.rd_en),
    .o_data(w_data),
    .o_full(w_full),
    .o_empty(w_empty),
    .o_count(w_count)
  );
  assign f.data_out = w_data;
  assign f.full = w_full;
  assign f.empty = w_empty;
  assign f.count = w_count;
  assign f.valid_out = r_valid;
  assign f.frame_done = r_done;
  assign f.overflow = r_ovf;
  assign f.underflow = r_udf;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cyc <= '0;
      r_valid <= 1'b0;
      r_done <= 1'b0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= r_ovf | (f.wr_en & w_full & ~f.rd_en);
      r_udf <= r_udf | (f.rd_en & w_empty);
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (f.start) r_state <= WAIT;
        WAIT: if (w_count >= CW'(FRAME_PIX)) begin
          r_state <= STREAM;
          r_valid <= 1'b1;
          r_cyc <= '0;
        end
        STREAM: begin
          r_cyc <= r_cyc + TW'(1);
          if (r_cyc == TW'(FRAME_CYC - 1)) begin
            r_state <= DONE;
            r_valid <= 1'b0;
            r_done <= 1'b1;
          end
        end
        DONE: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fmap_feeder.sv
// tb_fmap_feeder: table, directed and randomized checks against a queue-based frame model
module tb_fmap_feeder;
  localparam int DEPTH = 32;
  localparam int FRAME_PIX = 9;
  localparam int FRAME_CYC = 30;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  fmap_feeder_if #(.DATA_WIDTH(32), .DEPTH(DEPTH)) f();
  fmap_feeder #(.DATA_WIDTH(32), .DEPTH(DEPTH), .FRAME_PIX(FRAME_PIX), .FRAME_CYC(FRAME_CYC)) dut (
    .clk(clk),
    .rst(rst),
    .f(f)
  );
  always #5 clk = ~clk;
  logic [31:0] q[$];
  bit m_ovf, m_udf, m_wait, m_done;
  int m_left;
  typedef struct {bit wr; logic [31:0] d; bit rd; int cnt; logic [31:0] dout; bit emp; bit udf;} vec_t;
  vec_t tbl[8];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic tick();
    int sz;
    bit nd;
    @(posedge clk);
    sz = q.size();
    if (rst) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_wait = 0; m_done = 0; m_left = 0;
    end else begin
      if (f.rd_en && sz == 0) m_udf = 1;
      if (f.wr_en && sz == DEPTH && !f.rd_en) m_ovf = 1;
      nd = (m_left == 1);
      if (m_left > 0) m_left--;
      else if (m_wait && sz >= FRAME_PIX) begin m_left = FRAME_CYC; m_wait = 0; end
      else if (!m_wait && !m_done && f.start) m_wait = 1;
      m_done = nd;
      if (f.rd_en && sz > 0) void'(q.pop_front());
      if (f.wr_en && (sz < DEPTH || f.rd_en)) q.push_back(f.wr_data);
    end
    #1;
  endtask
  task automatic check_model();
    chk("m_valid", f.valid_out, m_left > 0);
    chk("m_done", f.frame_done, m_done);
    chk("m_data", f.data_out, q.size() > 0 ? q[0] : 32'h0);
    chk("m_count", f.count, q.size());
    chk("m_full", f.full, q.size() == DEPTH);
    chk("m_empty", f.empty, q.size() == 0);
    chk("m_ovf", f.overflow, m_ovf);
    chk("m_udf", f.underflow, m_udf);
  endtask
  task automatic drive(input bit w, input logic [31:0] d, input bit s, input bit r);
    f.wr_en = w; f.wr_data = d; f.start = s; f.rd_en = r;
    tick();
    check_model();
  endtask
  task automatic do_rst();
    rst = 1;
    f.wr_en = 0; f.wr_data = 0; f.start = 0; f.rd_en = 0;
    tick();
    rst = 0;
    check_model();
  endtask
  task automatic finish_frame();
    bit seen = 0;
    for (int t = 0; t < 80 && !seen; t++) begin
      drive(0, 0, 0, f.valid_out && !f.empty);
      seen = f.frame_done;
    end
    chk("frame_end_seen", seen, 1);
  endtask
  initial begin
    int nv, pops;
    bit seen, r;
    tbl[0] = '{1, 32'hA, 0, 1, 32'hA, 0, 0};
    tbl[1] = '{1, 32'hB, 0, 2, 32'hA, 0, 0};
    tbl[2] = '{1, 32'hC, 1, 2, 32'hB, 0, 0};
    tbl[3] = '{0, 32'h0, 1, 1, 32'hC, 0, 0};
    tbl[4] = '{0, 32'h0, 1, 0, 32'h0, 1, 0};
    tbl[5] = '{0, 32'h0, 1, 0, 32'h0, 1, 1};
    tbl[6] = '{1, 32'hD, 1, 1, 32'hD, 0, 1};
    tbl[7] = '{0, 32'h0, 0, 1, 32'hD, 0, 1};
    do_rst();
    chk("rst_valid", f.valid_out, 0);
    chk("rst_done", f.frame_done, 0);
    chk("rst_ovf", f.overflow, 0);
    chk("rst_udf", f.underflow, 0);
    chk("rst_empty", f.empty, 1);
    chk("rst_full", f.full, 0);
    chk("rst_data", f.data_out, 0);
    chk("rst_count", f.count, 0);
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].wr, tbl[i].d, 0, tbl[i].rd);
      chk($sformatf("tbl%0d_count", i), f.count, tbl[i].cnt);
      chk($sformatf("tbl%0d_data", i), f.data_out, tbl[i].dout);
      chk($sformatf("tbl%0d_empty", i), f.empty, tbl[i].emp);
      chk($sformatf("tbl%0d_udf", i), f.underflow, tbl[i].udf);
    end
    do_rst();
    for (int i = 0; i < 9; i++) drive(1, 32'h3F800000 + i, 0, 0);
    drive(0, 0, 1, 0);
    chk("frame_wait_valid", f.valid_out, 0);
    drive(0, 0, 0, 0);
    chk("frame_first_valid", f.valid_out, 1);
    nv = 1; pops = 0; seen = 0;
    for (int t = 0; t < 60 && !seen; t++) begin
      r = f.valid_out && pops < 9;
      if (r) begin
        chk("frame_pix", f.data_out, 32'h3F800000 + pops);
        pops++;
      end
      drive(0, 0, 0, r);
      if (f.valid_out) nv++;
      seen = f.frame_done;
    end
    chk("frame_len", nv, FRAME_CYC);
    chk("frame_done_seen", seen, 1);
    chk("frame_empty", f.empty, 1);
    drive(0, 0, 0, 0);
    chk("frame_done_pulse", f.frame_done, 0);
    do_rst();
    for (int i = 0; i < 4; i++) drive(1, 32'h100 + i, 0, 0);
    drive(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h200 + i, 0, 0);
      chk("hold_wait_valid", f.valid_out, 0);
    end
    chk("hold_count9", f.count, 9);
    drive(0, 0, 0, 0);
    chk("hold_valid_rise", f.valid_out, 1);
    finish_frame();
    do_rst();
    for (int i = 0; i < 32; i++) drive(1, 100 + i, 0, 0);
    chk("fill_full", f.full, 1);
    chk("fill_ovf0", f.overflow, 0);
    drive(1, 999, 0, 0);
    chk("ovf_count", f.count, 32);
    chk("ovf_flag", f.overflow, 1);
    chk("ovf_head", f.data_out, 100);
    for (int i = 0; i < 40; i++) begin
      drive(1, 200 + i, 0, 1);
      chk("wrap_count", f.count, 32);
    end
    for (int i = 0; i < 32; i++) begin
      chk("wrap_order", f.data_out, 208 + i);
      drive(0, 0, 0, 1);
    end
    chk("wrap_empty", f.empty, 1);
    chk("ovf_sticky", f.overflow, 1);
    do_rst();
    drive(0, 0, 0, 1);
    chk("udf_data", f.data_out, 0);
    chk("udf_count", f.count, 0);
    chk("udf_flag", f.underflow, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
    chk("udf_sticky", f.underflow, 1);
    do_rst();
    chk("udf_cleared", f.underflow, 0);
    for (int i = 0; i < 9; i++) drive(1, 32'h300 + i, 0, 0);
    drive(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 0);
    chk("abort_streaming", f.valid_out, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("abort_valid", f.valid_out, 0);
    chk("abort_count", f.count, 0);
    chk("abort_done", f.frame_done, 0);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      drive(0, 0, 0, 0);
      seen = seen | f.frame_done | f.valid_out;
    end
    chk("abort_quiet", seen, 0);
    drive(0, 0, 1, 0);
    for (int i = 0; i < 9; i++) drive(1, 32'h400 + i, 0, 0);
    drive(0, 0, 0, 0);
    chk("abort_idle_restart", f.valid_out, 1);
    finish_frame();
    do_rst();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_rst();
      else drive($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
